// File: rtl/ram_arbiter_if.sv
// Signal bundle between the four cache requesters, the shared-RAM arbiter and the RAM model.
// Index 0/1 are icache0/icache1, 2/3 are dcache0/dcache1.
interface ram_arbiter_if;
    logic [3:0]       req;
    logic [3:0]       wen;
    logic [3:0]       burst;
    logic [3:0][31:0] addr;
    logic [3:0][31:0] wdata;
    logic [3:0]       rwait;
    logic [3:0][31:0] rdata;
    logic [31:0]      ramaddr;
    logic [31:0]      ramstore;
    logic             ramREN;
    logic             ramWEN;
    logic [31:0]      ramload;
    logic [1:0]       ramstate;
    logic [1:0]       owner;
    logic             busy;

    modport master (
        input  req, wen, burst, addr, wdata, ramload, ramstate,
        output rwait, rdata, ramaddr, ramstore, ramREN, ramWEN, owner, busy
    );

    modport slave (
        output req, wen, burst, addr, wdata, ramload, ramstate,
        input  rwait, rdata, ramaddr, ramstore, ramREN, ramWEN, owner, busy
    );
endinterface

// File: rtl/ram_arbiter.sv
// Four-way arbiter/sequencer for the single shared RAM port: class priority (dcache over icache),
// round-robin within each class, and starvation promotion for the icaches.
module ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    ram_arbiter_if.master bus
);
    localparam logic [1:0] RAM_ACCESS = 2'b10;

    typedef enum logic [1:0] {IDLE, XFER0, XFER1} state_t;

    state_t     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic       burst_q, burst_d;
    logic       irr_q, irr_d;   // icache index that wins an icache tie
    logic       drr_q, drr_d;   // dcache offset that wins a dcache tie (0 -> requester 2)
    logic [2:0] starve_q [2];
    logic [2:0] starve_d [2];

    logic [1:0] promo;
    logic [1:0] win;
    logic       grant;
    logic       live;
    logic       ack;

    function automatic logic pick2(input logic [1:0] m, input logic pref);
        return (&m) ? pref : m[1];
    endfunction

    assign grant = (state_q == IDLE) && (|bus.req);
    assign live  = bus.req[owner_q];
    assign ack   = (state_q != IDLE) && live && (bus.ramstate == RAM_ACCESS);

    always_comb begin
        promo = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            promo[i] = bus.req[i] && ({29'd0, starve_q[i]} >= STARVE_LIMIT);
        end
        win = '0;
        if (|promo) begin
            win = {1'b0, pick2(promo, irr_q)};
        end else if (|bus.req[3:2]) begin
            win = {1'b1, pick2(bus.req[3:2], drr_q)};
        end else begin
            win = {1'b0, pick2(bus.req[1:0], irr_q)};
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        burst_d = burst_q;
        irr_d   = irr_q;
        drr_d   = drr_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = XFER0;
                    owner_d = win;
                    burst_d = bus.burst[win];
                    if (win[1]) drr_d = ~win[0];
                    else        irr_d = ~win[0];
                end
            end
            XFER0, XFER1: begin
                // A dropped request abandons the transfer, including the rest of a burst.
                if (!live)    state_d = IDLE;
                else if (ack) state_d = (state_q == XFER0 && burst_q) ? XFER1 : IDLE;
            end
            default: state_d = IDLE;
        endcase

        for (int unsigned i = 0; i < 2; i++) begin
            starve_d[i] = starve_q[i];
            if (!bus.req[i] || (grant && win == 2'(i))) begin
                starve_d[i] = '0;
            end else if (grant && win[1] && starve_q[i] != '1) begin
                starve_d[i] = starve_q[i] + 3'd1;
            end
        end
    end

    always_comb begin
        bus.rwait    = '1;
        bus.rdata    = '0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.owner    = '0;
        bus.busy     = 1'b0;
        if (state_q != IDLE) begin
            bus.busy              = 1'b1;
            bus.owner             = owner_q;
            bus.ramaddr           = bus.addr[owner_q];
            bus.ramstore          = bus.wen[owner_q] ? bus.wdata[owner_q] : '0;
            bus.ramREN            = ~bus.wen[owner_q] & live;
            bus.ramWEN            = bus.wen[owner_q] & live;
            bus.rdata[owner_q]    = bus.ramload;
            if (ack) bus.rwait[owner_q] = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            burst_q     <= 1'b0;
            irr_q       <= 1'b0;
            drr_q       <= 1'b0;
            starve_q[0] <= '0;
            starve_q[1] <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            burst_q     <= burst_d;
            irr_q       <= irr_d;
            drr_q       <= drr_d;
            starve_q[0] <= starve_d[0];
            starve_q[1] <= starve_d[1];
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and randomized bench for ram_arbiter against a transaction-level reference model.
module tb_ram_arbiter;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic CLK = 1'b0;
    logic nRST = 1'b0;

    ram_arbiter_if bus ();

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who holds the port, how many words remain, tie pointers, starvation counts.
    int m_busy, m_owner, m_left, m_inext, m_dnext;
    int m_starve [2];
    int r_left [4];
    bit hold_mode = 1'b0;
    logic [3:0] exp_rwait = '1;
    int dut_grants [$];
    bit prev_busy = 1'b0;
    int exp_order [12] = '{2, 3, 2, 3, 0, 1, 2, 3, 2, 3, 0, 1};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_left = 0; m_inext = 0; m_dnext = 0;
        m_starve[0] = 0; m_starve[1] = 0;
    endtask

    function automatic int choose();
        int cand [$];
        for (int i = 0; i < 2; i++) if (bus.req[i] && m_starve[i] >= 4) cand.push_back(i);
        if (cand.size() == 0) for (int i = 2; i < 4; i++) if (bus.req[i]) cand.push_back(i);
        if (cand.size() == 0) for (int i = 0; i < 2; i++) if (bus.req[i]) cand.push_back(i);
        if (cand.size() == 1) return cand[0];
        return (cand[0] >= 2) ? 2 + m_dnext : m_inext;
    endfunction

    task automatic model_edge();
        int w;
        w = -1;
        if (!nRST) begin
            model_reset();
            return;
        end
        if (m_busy == 0) begin
            if (|bus.req) begin
                w = choose();
                m_busy = 1; m_owner = w; m_left = bus.burst[w] ? 2 : 1;
                if (w >= 2) m_dnext = (w == 2) ? 1 : 0;
                else        m_inext = (w == 0) ? 1 : 0;
            end
        end else if (!bus.req[m_owner]) begin
            m_busy = 0;
        end else if (bus.ramstate == ACCESS) begin
            m_left--;
            if (m_left == 0) m_busy = 0;
        end
        for (int i = 0; i < 2; i++) begin
            if (!bus.req[i] || w == i)        m_starve[i] = 0;
            else if (w >= 2 && m_starve[i] < 7) m_starve[i]++;
        end
    endtask

    task automatic start(input int i, input bit w, input bit b, input logic [31:0] a);
        bus.req[i] = 1'b1; bus.wen[i] = w; bus.burst[i] = b;
        bus.addr[i] = a; bus.wdata[i] = $urandom;
        r_left[i] = b ? 2 : 1;
    endtask

    task automatic requester_update();
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i] && !exp_rwait[i]) begin
                r_left[i]--;
                if (r_left[i] == 0) begin
                    if (hold_mode) start(i, 1'b0, 1'b0, $urandom & 32'hFFFC);
                    else           bus.req[i] = 1'b0;
                end else begin
                    bus.addr[i] = bus.addr[i] + 32'd4;
                    bus.wdata[i] = $urandom;
                end
            end
        end
    endtask

    task automatic advance();
        @(posedge CLK);
        #1;
        model_edge();
        requester_update();
    endtask

    task automatic compare();
        logic [3:0]       e_rwait;
        logic [3:0][31:0] e_rdata;
        logic [31:0]      e_addr, e_store;
        logic             e_ren, e_wen, e_busy;
        logic [1:0]       e_owner;
        #2;
        e_rwait = '1; e_rdata = '0; e_addr = '0; e_store = '0;
        e_ren = 1'b0; e_wen = 1'b0; e_busy = 1'b0; e_owner = '0;
        if (m_busy != 0) begin
            e_busy  = 1'b1;
            e_owner = 2'(m_owner);
            e_addr  = bus.addr[m_owner];
            e_store = bus.wen[m_owner] ? bus.wdata[m_owner] : 32'd0;
            e_ren   = !bus.wen[m_owner] && bus.req[m_owner];
            e_wen   = bus.wen[m_owner] && bus.req[m_owner];
            e_rdata[m_owner] = bus.ramload;
            if (bus.req[m_owner] && bus.ramstate == ACCESS) e_rwait[m_owner] = 1'b0;
        end
        exp_rwait = e_rwait;
        chk("rwait",    128'(bus.rwait),    128'(e_rwait));
        chk("rdata",    128'(bus.rdata),    128'(e_rdata));
        chk("ramaddr",  128'(bus.ramaddr),  128'(e_addr));
        chk("ramstore", 128'(bus.ramstore), 128'(e_store));
        chk("ramREN",   128'(bus.ramREN),   128'(e_ren));
        chk("ramWEN",   128'(bus.ramWEN),   128'(e_wen));
        chk("owner",    128'(bus.owner),    128'(e_owner));
        chk("busy",     128'(bus.busy),     128'(e_busy));
        chk("ren_wen_excl", 128'(bus.ramREN & bus.ramWEN), 128'(0));
        if (bus.busy === 1'b1 && !prev_busy) dut_grants.push_back(int'(bus.owner));
        prev_busy = (bus.busy === 1'b1);
    endtask

    task automatic cycle();
        advance();
        compare();
    endtask

    initial begin
        int x;
        bus.req = '0; bus.wen = '0; bus.burst = '0; bus.addr = '0; bus.wdata = '0;
        bus.ramload = '0; bus.ramstate = FREE;
        for (int i = 0; i < 4; i++) r_left[i] = 0;
        model_reset();

        // Reset values
        repeat (2) cycle();
        nRST = 1'b1;
        cycle();

        // Single read with two BUSY cycles
        advance(); start(2, 1'b0, 1'b0, 32'h40); bus.ramstate = BUSY; bus.ramload = 32'hDEADBEEF; compare();
        advance(); compare();
        advance(); compare();
        advance(); bus.ramstate = ACCESS; compare();
        chk("rd_data", 128'(bus.rdata[2]), 128'(32'hDEADBEEF));
        chk("rd_pulse", 128'(bus.rwait), 128'(4'b1011));
        advance(); bus.ramstate = FREE; compare();

        // Burst write, immediate ACCESS
        advance(); start(3, 1'b1, 1'b1, 32'h80); bus.ramstate = ACCESS; compare();
        advance(); compare(); chk("bw_addr0", 128'(bus.ramaddr), 128'(32'h80));
        advance(); compare(); chk("bw_addr1", 128'(bus.ramaddr), 128'(32'h84));
        advance(); compare();

        // Contention: all four held high
        hold_mode = 1'b1;
        advance();
        for (int i = 0; i < 4; i++) start(i, 1'b0, 1'b0, $urandom & 32'hFFFC);
        dut_grants.delete();
        compare();
        repeat (24) cycle();
        hold_mode = 1'b0;
        repeat (10) cycle();
        for (int k = 0; k < 12; k++)
            chk("grant_order", 128'((k < dut_grants.size()) ? dut_grants[k] : 99), 128'(exp_order[k]));

        // Abort in XFER1 with a pending dcache request
        advance(); start(1, 1'b0, 1'b1, 32'h100); bus.ramstate = ACCESS; compare();
        advance(); start(2, 1'b0, 1'b0, 32'h200); compare();
        advance(); bus.ramstate = BUSY; compare();
        advance(); bus.req[1] = 1'b0; r_left[1] = 0; bus.ramstate = ACCESS; compare();
        chk("ab_nopulse", 128'(bus.rwait), 128'(4'b1111));
        advance(); compare(); chk("ab_idle", 128'(bus.busy), 128'(0));
        advance(); compare(); chk("ab_grant2", 128'(bus.owner), 128'(2));
        advance(); compare();

        // Asynchronous reset during XFER0
        advance(); start(0, 1'b0, 1'b0, 32'h300); bus.ramstate = BUSY; compare();
        advance(); compare();
        nRST = 1'b0; model_reset(); compare();
        chk("rst_rwait", 128'(bus.rwait), 128'(4'b1111));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        advance(); bus.req = '0; for (int i = 0; i < 4; i++) r_left[i] = 0; compare();
        nRST = 1'b1;
        advance(); compare();
        advance(); start(2, 1'b0, 1'b0, 32'h10); start(3, 1'b0, 1'b0, 32'h20); bus.ramstate = ACCESS; compare();
        advance(); compare(); chk("rst_rr", 128'(bus.owner), 128'(2));
        repeat (4) cycle();

        // ERROR hold then ACCESS
        advance(); start(3, 1'b1, 1'b0, 32'h400); bus.ramstate = ERROR; compare();
        repeat (5) begin
            advance(); compare();
            chk("err_addr", 128'(bus.ramaddr), 128'(32'h400));
            chk("err_hold", 128'(bus.rwait), 128'(4'b1111));
        end
        advance(); bus.ramstate = ACCESS; compare();
        chk("err_pulse", 128'(bus.rwait), 128'(4'b0111));
        advance(); bus.ramstate = FREE; compare();

        // Randomized traffic
        repeat (600) begin
            advance();
            for (int i = 0; i < 4; i++) begin
                if (!bus.req[i] && $urandom_range(99) < 30)
                    start(i, 1'($urandom_range(1)), 1'($urandom_range(1)), $urandom & 32'hFFFC);
                else if (bus.req[i] && $urandom_range(99) < 3) begin
                    bus.req[i] = 1'b0;
                    r_left[i] = 0;
                end
            end
            x = int'($urandom_range(9));
            if (x < 6)      bus.ramstate = ACCESS;
            else if (x < 8) bus.ramstate = BUSY;
            else if (x < 9) bus.ramstate = ERROR;
            else            bus.ramstate = FREE;
            bus.ramload = $urandom;
            compare();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
